pattern_event_logger: RTL and testbench
=======================================

# pattern_event_logger

Downstream consumer of the serial sequence detector's one-cycle `pattern_found` pulse. The block counts detected matches with saturation and timestamps every match against a free-running cycle counter. It queues the timestamps in a small first-word-fall-through FIFO that software or a host-side reader drains with a valid/ready handshake. A level interrupt flags when the queue reaches a programmable fill level.

## Interface
- `CNT_WIDTH`, default 16: width of the saturating match counter.
- `TS_WIDTH`, default 16: width of the free-running timestamp counter and of each FIFO entry.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥2.
- `IRQ_LEVEL`, default 3: occupancy at or above which `o_irq` asserts; range 1..DEPTH.
- `i_clk` in 1: single clock; all logic on its rising edge.
- `i_resetn` in 1: asynchronous, active-low reset.
- `i_pattern_found` in 1: match pulse from the detector, sampled every rising edge.
- `i_clear` in 1: synchronous clear of counter, FIFO, overflow flag and interrupt.
- `i_evt_ready` in 1: reader accepts the head entry this cycle.
- `o_evt_valid` out 1: FIFO not empty; the head entry is presented.
- `o_evt_timestamp` out TS_WIDTH: head-entry timestamp; valid only while `o_evt_valid`=1.
- `o_match_count` out CNT_WIDTH: total matches since reset/clear, saturating.
- `o_overflow` out 1: sticky; at least one event was dropped because the FIFO was full.
- `o_irq` out 1: level; occupancy ≥ IRQ_LEVEL.

## Operation
- **Timestamp counter `ts`**
  - 0 at reset; +1 every cycle; wraps modulo 2^TS_WIDTH.
  - Not affected by `i_clear`.
- **Match counter**
  - +1 on each sampled `i_pattern_found`=1.
  - Holds at all-ones.
  - Dropped events are still counted.
- **Push**: `i_pattern_found`=1 writes the current `ts` value (the value before this edge's increment) at the tail.
- **Pop**: `o_evt_valid`=1 and `i_evt_ready`=1 removes the head. `i_evt_ready` while empty is ignored.
- **FIFO status FSM**, states EMPTY / PARTIAL / FULL, derived from the occupancy count:
  - EMPTY: push → PARTIAL (DEPTH≥2); pop is ignored.
  - PARTIAL: push only → occupancy +1, FULL when it reaches DEPTH; pop only → occupancy −1, EMPTY at 0; push+pop → unchanged.
  - FULL: pop only → PARTIAL; push+pop → stays FULL, with the oldest entry out and the new entry in, and no overflow; push only → entry dropped, `o_overflow` set.
- **Pointers**: read/write pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
- **Ordering**: entries come out strictly in push order.
- **`i_clear`**
  - Occupancy, pointers, match counter, overflow and irq go to 0 at the next edge.
  - Overrides a simultaneous push or pop; that event is neither stored nor counted.
- **Async reset mid-operation**: immediately forces every output to 0 and `ts` to 0. Queued events are lost.

## Timing
- **Reset values**: `o_evt_valid`=0, `o_evt_timestamp`=0, `o_match_count`=0, `o_overflow`=0, `o_irq`=0.
- **Latency**
  - A pulse sampled at edge N makes `o_match_count`, `o_evt_valid`, `o_irq` and `o_overflow` reflect it after edge N (1 cycle).
  - Its timestamp equals the `ts` value held during the cycle before edge N.
- **Outputs**: all are registered or decoded only from registers. There is no combinational path from inputs to outputs.
- **Pop timing**: `o_evt_timestamp` changes to the next entry in the cycle after an accepted pop.
- **Throughput**: one push and one pop per cycle, sustained.
- **Handshake**: `o_evt_valid` never deasserts without a pop, except on clear or reset.

## Structure
- **Package `pattern_logger_pkg`**: default widths, DEPTH, IRQ_LEVEL, and the FIFO status state encoding (EMPTY/PARTIAL/FULL).
- **Sub-module `pattern_evt_fifo`**:
  - Parameterised TS_WIDTH×DEPTH, first-word-fall-through, with a sync clear.
  - Exports occupancy, full and empty.
- **Top level**: `ts` counter, match counter, overflow/irq logic.

## Test plan
- **Reset**: hold `i_resetn`=0 while driving pulses → all outputs stay 0. Release; pulse at the first edge → timestamp 0, count 1.
- **Single event**: pulse sampled while `ts`=10 → next cycle `o_evt_valid`=1, timestamp 10, count 1. `i_evt_ready`=1 for one cycle → valid 0 the following cycle.
- **Fill and overflow** (DEPTH=4, IRQ_LEVEL=3, ready=0): pulses at `ts`=2,4,6,8,10 → irq rises after the 3rd, FULL after the 4th, overflow after the 5th, count 5. Draining yields 2,4,6,8.
- **Simultaneous push/pop while FULL** (holding 2,4,6,8): pop + pulse at `ts`=20 → no overflow, occupancy 4, drain order 4,6,8,20.
- **Saturation and wrap** (CNT_WIDTH=3, TS_WIDTH=4): 9 pulses → count stays 7. Pulse at absolute cycle 17 → timestamp 1.
- **Clear vs. pulse, mid-run reset**: `i_clear` and a pulse in the same cycle → count 0, valid 0, overflow 0, `ts` keeps running. Asserting `i_resetn` low mid-queue → outputs 0 asynchronously.

Source files
------------

// File: rtl/pattern_logger_pkg.sv
// Shared defaults and FIFO status encoding for the pattern event logger.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pattern_logger_pkg;

    localparam int CNT_WIDTH_DEF = 16;
    localparam int TS_WIDTH_DEF  = 16;
    localparam int DEPTH_DEF     = 4;
    localparam int IRQ_LEVEL_DEF = 3;

    // Occupancy class of the event FIFO; PARTIAL covers 1..DEPTH-1 entries.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/pattern_evt_fifo.sv
// First-word-fall-through timestamp FIFO with synchronous clear and EMPTY/PARTIAL/FULL status.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push while FULL without a pop is dropped; push+pop while FULL replaces oldest.
//
// Ports: i_clk/i_resetn clock and async active-low reset; i_clear sync clear (wins over push/pop);
//        i_push/i_push_data write request; i_pop remove head (ignored when empty);
//        o_data head entry (0 when empty); o_count occupancy; o_full/o_empty status.
module pattern_evt_fifo
    import pattern_logger_pkg::*;
#(
    parameter int TS_WIDTH = TS_WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_clear,
    input  logic                i_push,
    input  logic [TS_WIDTH-1:0] i_push_data,
    input  logic                i_pop,
    output logic [TS_WIDTH-1:0] o_data,
    output logic [AW:0]         o_count,
    output logic                o_full,
    output logic                o_empty
);

    localparam logic [AW:0]   CNT_ONE      = (AW+1)'(1);
    localparam logic [AW:0]   CNT_NEARFULL = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE      = AW'(1);

    logic [TS_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    fifo_state_t         state;
    logic                do_pop;
    logic                do_push;

    // When full, a simultaneous pop frees the slot the write pointer points at.
    assign do_pop  = i_pop && (state != ST_EMPTY);
    assign do_push = i_push && ((state != ST_FULL) || do_pop);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= ST_EMPTY;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= ST_EMPTY;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case (state)
                ST_EMPTY: begin
                    if (do_push) begin
                        count <= CNT_ONE;
                        state <= ST_PARTIAL;
                    end
                end
                ST_PARTIAL: begin
                    if (do_push && !do_pop) begin
                        count <= count + CNT_ONE;
                        if (count == CNT_NEARFULL) state <= ST_FULL;
                    end else if (do_pop && !do_push) begin
                        count <= count - CNT_ONE;
                        if (count == CNT_ONE) state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (do_pop && !do_push) begin
                        count <= count - CNT_ONE;
                        state <= ST_PARTIAL;
                    end
                end
                default: begin
                    count <= '0;
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (do_push && !i_clear) mem[wr_ptr] <= i_push_data;
    end

    assign o_empty = (state == ST_EMPTY);
    assign o_full  = (state == ST_FULL);
    assign o_count = count;
    assign o_data  = o_empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pattern_event_logger.sv
// Counts pattern_found pulses (saturating) and queues a cycle timestamp per match for a reader.
// Latency: a pulse sampled at edge N shows on count/valid/irq/overflow right after edge N.
// Backpressure: reader uses valid/ready; events arriving while the queue is full are dropped (sticky overflow).
//
// Ports: i_clk/i_resetn clock and async active-low reset; i_pattern_found match pulse;
//        i_clear sync clear of counter, queue, overflow, irq; i_evt_ready reader accept;
//        o_evt_valid/o_evt_timestamp queue head; o_match_count saturating total;
//        o_overflow sticky drop flag; o_irq occupancy >= IRQ_LEVEL.
module pattern_event_logger
    import pattern_logger_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int TS_WIDTH  = TS_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int IRQ_LEVEL = IRQ_LEVEL_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic                 i_pattern_found,
    input  logic                 i_clear,
    input  logic                 i_evt_ready,
    output logic                 o_evt_valid,
    output logic [TS_WIDTH-1:0]  o_evt_timestamp,
    output logic [CNT_WIDTH-1:0] o_match_count,
    output logic                 o_overflow,
    output logic                 o_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]          IRQ_CNT = (AW+1)'(IRQ_LEVEL);
    localparam logic [TS_WIDTH-1:0]  TS_ONE  = TS_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [TS_WIDTH-1:0]  ts;
    logic [CNT_WIDTH-1:0] match_count;
    logic                 overflow;
    logic [AW:0]          fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    assign pop = !fifo_empty && i_evt_ready;

    // Free-running timestamp; deliberately untouched by i_clear.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) ts <= '0;
        else           ts <= ts + TS_ONE;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (i_clear) begin
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            // Dropped events still count toward the total.
            if (i_pattern_found && (match_count != '1)) match_count <= match_count + CNT_ONE;
            if (i_pattern_found && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    // The pushed value is ts before this edge's increment.
    pattern_evt_fifo #(
        .TS_WIDTH (TS_WIDTH),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_resetn    (i_resetn),
        .i_clear     (i_clear),
        .i_push      (i_pattern_found),
        .i_push_data (ts),
        .i_pop       (pop),
        .o_data      (o_evt_timestamp),
        .o_count     (fifo_count),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    assign o_evt_valid   = !fifo_empty;
    assign o_match_count = match_count;
    assign o_overflow    = overflow;
    assign o_irq         = (fifo_count >= IRQ_CNT);

endmodule

// File: tb/tb_pattern_event_logger.sv
// Scoreboard bench for pattern_event_logger (CNT_WIDTH=3, TS_WIDTH=4, DEPTH=4, IRQ_LEVEL=3).
// Latency: n/a.
// Backpressure: bench drives i_evt_ready directly.
module tb_pattern_event_logger;

    logic       clk;
    logic       rst_n;
    logic       pf;
    logic       clr;
    logic       rdy;
    logic       evt_valid;
    logic [3:0] evt_ts;
    logic [2:0] match_count;
    logic       overflow;
    logic       irq;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [3:0] q [$];
    logic [3:0] ts_m;
    int         m_cnt;
    bit         m_ovf;
    bit         pop_m;

    pattern_event_logger #(
        .CNT_WIDTH (3),
        .TS_WIDTH  (4),
        .DEPTH     (4),
        .IRQ_LEVEL (3)
    ) dut (
        .i_clk           (clk),
        .i_resetn        (rst_n),
        .i_pattern_found (pf),
        .i_clear         (clr),
        .i_evt_ready     (rdy),
        .o_evt_valid     (evt_valid),
        .o_evt_timestamp (evt_ts),
        .o_match_count   (match_count),
        .o_overflow      (overflow),
        .o_irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model updates on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            ts_m  = 4'd0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            pop_m = (q.size() != 0) && rdy;
            if (clr) begin
                q.delete();
                m_cnt = 0;
                m_ovf = 1'b0;
            end else begin
                if (pop_m) void'(q.pop_front());
                if (pf) begin
                    if (q.size() < 4) q.push_back(ts_m);
                    else              m_ovf = 1'b1;
                    if (m_cnt != 7) m_cnt++;
                end
            end
            ts_m = ts_m + 4'd1;
        end
    end

    // Per-cycle comparison of all outputs against the scoreboard.
    always @(negedge clk) begin
        #2;
        check("valid", 32'(evt_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("head_ts", 32'(evt_ts), 32'(q[0]));
        check("count", 32'(match_count), 32'(m_cnt));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("irq", 32'(irq), 32'(q.size() >= 3));
    end

    task automatic wait_ts(input int t);
        for (int i = 0; i < 40 && ts_m != 4'(t); i++) @(negedge clk);
    endtask

    task automatic pulse();
        pf = 1'b1;
        @(negedge clk);
        pf = 1'b0;
    endtask

    task automatic drain(input int n);
        rdy = 1'b1;
        repeat (n) @(negedge clk);
        rdy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; pf = 1'b0; clr = 1'b0; rdy = 1'b0;

        // Pulses during reset are ignored
        @(negedge clk); pf = 1'b1;
        @(negedge clk);
        @(negedge clk); #3;
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_ts", 32'(evt_ts), 0);
        check("rst_count", 32'(match_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_irq", 32'(irq), 0);

        // Release with pulse at the first edge
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); pf = 1'b0; #3;
        check("first_ts", 32'(evt_ts), 0);
        check("first_count", 32'(match_count), 1);
        drain(1); #3;
        check("first_drained", 32'(evt_valid), 0);

        // Single event at ts=10
        wait_ts(10); pulse(); #3;
        check("single_valid", 32'(evt_valid), 1);
        check("single_ts", 32'(evt_ts), 10);
        drain(1); #3;
        check("single_drained", 32'(evt_valid), 0);

        // Fill and overflow
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        wait_ts(2);  pulse();
        wait_ts(4);  pulse();
        wait_ts(6);  pulse(); #3;
        check("fill3_irq", 32'(irq), 1);
        wait_ts(8);  pulse(); #3;
        check("fill4_ovf", 32'(overflow), 0);
        wait_ts(10); pulse(); #3;
        check("fill5_ovf", 32'(overflow), 1);
        check("fill5_count", 32'(match_count), 5);
        check("fill5_head", 32'(evt_ts), 2);
        drain(4); #3;
        check("fill_drained", 32'(evt_valid), 0);

        // Clear and pulse together
        pulse(); pulse();
        pf = 1'b1; clr = 1'b1;
        @(negedge clk); pf = 1'b0; clr = 1'b0; #3;
        check("clr_count", 32'(match_count), 0);
        check("clr_valid", 32'(evt_valid), 0);
        check("clr_ovf", 32'(overflow), 0);
        check("clr_irq", 32'(irq), 0);

        // Push + pop while full
        wait_ts(2); pulse();
        wait_ts(4); pulse();
        wait_ts(6); pulse();
        wait_ts(8); pulse();
        wait_ts(4);
        pf = 1'b1; rdy = 1'b1;
        @(negedge clk); pf = 1'b0; rdy = 1'b0; #3;
        check("pp_ovf", 32'(overflow), 0);
        check("pp_irq", 32'(irq), 1);
        check("pp_head", 32'(evt_ts), 4);
        drain(4); #3;
        check("pp_drained", 32'(evt_valid), 0);

        // Counter saturation
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        rdy = 1'b1; pf = 1'b1;
        repeat (9) @(negedge clk);
        pf = 1'b0; #3;
        check("sat_count", 32'(match_count), 7);
        @(negedge clk); rdy = 1'b0;

        // Timestamp wrap
        wait_ts(1); pulse(); #3;
        check("wrap_ts", 32'(evt_ts), 1);
        drain(1);

        // Asynchronous reset mid-queue
        pf = 1'b1;
        repeat (3) @(negedge clk);
        pf = 1'b0;
        @(negedge clk); #3;
        rst_n = 1'b0; #1;
        check("arst_valid", 32'(evt_valid), 0);
        check("arst_ts", 32'(evt_ts), 0);
        check("arst_count", 32'(match_count), 0);
        check("arst_ovf", 32'(overflow), 0);
        check("arst_irq", 32'(irq), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
